// File: rtl/sha_seq_pkg.sv
// Shared types and defaults for the SHA round sequencer.
package sha_seq_pkg;

   localparam int unsigned ROUNDS_DEF    = 64;
   localparam int unsigned HDR_WORDS_DEF = 20;
   localparam int unsigned NONCE_IDX_DEF = 19;
   localparam int unsigned PIPE_LAT_DEF  = 4;

   // First round that takes W[t] from the message-schedule expander instead of the header.
   localparam int unsigned SCHED_SW_RND  = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ARMED,
      S_INIT,
      S_PRIME,
      S_ROUND,
      S_WAIT_DS,
      S_FINISH
   } state_t;

endpackage

// File: rtl/sha_seq_nonce_ctr.sv
// Nonce register with range end-compare and sticky exhausted flag.
module sha_seq_nonce_ctr (
   input  logic        clk_h,
   input  logic        host_break,
   input  logic        arm,
   input  logic        inc,
   input  logic        set_exh,
   input  logic [31:0] nonce_start,
   input  logic [31:0] nonce_end,
   output logic [31:0] nonce,
   output logic        last_c,
   output logic        exhausted
);

   logic [31:0] end_q;
   logic        single_q;

   // A reversed range runs the start nonce alone, so it is always the last one.
   always_comb begin
      last_c = single_q || (nonce == end_q);
   end

   // Range capture on arm, modulo-2^32 increment, sticky exhausted.
   always_ff @(posedge clk_h) begin
      if (host_break) begin
         nonce     <= '0;
         end_q     <= '0;
         single_q  <= 1'b0;
         exhausted <= 1'b0;
      end else if (arm) begin
         nonce     <= nonce_start;
         end_q     <= nonce_end;
         single_q  <= (nonce_start > nonce_end);
         exhausted <= 1'b0;
      end else begin
         if (inc)     nonce     <= nonce + 32'd1;
         if (set_exh) exhausted <= 1'b1;
      end
   end

endmodule

// File: rtl/sha_round_seq.sv
// Control sequencer for a SHA-256 compression core: header load, per-nonce round
// sequencing and downstream hand-off.
module sha_round_seq
   import sha_seq_pkg::*;
#(
   parameter int unsigned ROUNDS    = ROUNDS_DEF,
   parameter int unsigned HDR_WORDS = HDR_WORDS_DEF,
   parameter int unsigned NONCE_IDX = NONCE_IDX_DEF,
   parameter int unsigned PIPE_LAT  = PIPE_LAT_DEF
) (
   input  logic                         clk_h,
   input  logic                         host_break,
   input  logic                         block_data_en,
   input  logic                         start_stop,
   input  logic [31:0]                  nonce_start,
   input  logic [31:0]                  nonce_end,
   input  logic                         ds_ready,
   output logic                         hdr_wren,
   output logic [$clog2(HDR_WORDS)-1:0] hdr_addr_a,
   output logic [$clog2(HDR_WORDS)-1:0] hdr_addr_b,
   output logic [$clog2(ROUNDS)-1:0]    k_addr,
   output logic                         k_en,
   output logic                         abc_load,
   output logic                         abc_en,
   output logic                         wt_reg_en,
   output logic                         wt_sw,
   output logic                         wr_nonce,
   output logic [31:0]                  nonce_out,
   output logic                         go_next,
   output logic                         busy,
   output logic                         exhausted
);

   localparam int unsigned HAW = $clog2(HDR_WORDS);
   localparam int unsigned WCW = HAW + 1;
   localparam int unsigned RW  = $clog2(ROUNDS);
   localparam int unsigned PW  = 4;

   state_t         state_q, state_d;
   logic [WCW-1:0] wcnt_q;
   logic [HAW-1:0] baddr_q;
   logic [RW-1:0]  rc_q;
   logic [PW-1:0]  pcnt_q;

   logic hdr_room_c, prime_last_c, round_last_c;
   logic nonce_last_c, nonce_arm, nonce_inc, nonce_set_exh;

   // Round counter doubles as the K ROM address.
   assign k_addr     = rc_q;
   assign hdr_addr_b = baddr_q;

   // Counter terminal decodes.
   always_comb begin
      hdr_room_c   = (wcnt_q < WCW'(HDR_WORDS));
      prime_last_c = (pcnt_q == PW'(PIPE_LAT - 1));
      round_last_c = (rc_q == RW'(ROUNDS - 1));
   end

   // State register.
   always_ff @(posedge clk_h) begin
      if (host_break) state_q <= S_IDLE;
      else            state_q <= state_d;
   end

   // Next-state and control decode.
   always_comb begin
      state_d       = state_q;
      hdr_wren      = 1'b0;
      hdr_addr_a    = '0;
      k_en          = 1'b0;
      abc_load      = 1'b0;
      abc_en        = 1'b0;
      wt_reg_en     = 1'b0;
      wt_sw         = 1'b0;
      wr_nonce      = 1'b0;
      go_next       = 1'b0;
      busy          = 1'b1;
      nonce_arm     = 1'b0;
      nonce_inc     = 1'b0;
      nonce_set_exh = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (block_data_en) begin
               hdr_wren = 1'b1;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            busy       = 1'b0;
            hdr_addr_a = wcnt_q[HAW-1:0];
            if (block_data_en)   hdr_wren = hdr_room_c;
            else if (start_stop) state_d  = S_ARMED;
         end
         S_ARMED: begin
            nonce_arm = 1'b1;
            state_d   = S_INIT;
         end
         S_INIT: begin
            wr_nonce   = 1'b1;
            hdr_addr_a = HAW'(NONCE_IDX);
            abc_load   = 1'b1;
            abc_en     = 1'b1;
            state_d    = S_PRIME;
         end
         S_PRIME: begin
            abc_load  = 1'b1;
            abc_en    = 1'b1;
            k_en      = prime_last_c;
            wt_reg_en = prime_last_c;
            if (prime_last_c) state_d = S_ROUND;
         end
         S_ROUND: begin
            abc_en    = 1'b1;
            k_en      = 1'b1;
            wt_reg_en = 1'b1;
            wt_sw     = (rc_q >= RW'(SCHED_SW_RND));
            if (round_last_c) state_d = S_WAIT_DS;
         end
         S_WAIT_DS: begin
            go_next = 1'b1;
            if (ds_ready) state_d = S_FINISH;
         end
         S_FINISH: begin
            if (nonce_last_c) begin
               nonce_set_exh = 1'b1;
               state_d       = S_IDLE;
            end else if (!start_stop) begin
               state_d = S_IDLE;
            end else begin
               nonce_inc = 1'b1;
               state_d   = S_INIT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Header word count, header read address, prime and round counters.
   always_ff @(posedge clk_h) begin
      if (host_break) begin
         wcnt_q  <= '0;
         baddr_q <= '0;
         rc_q    <= '0;
         pcnt_q  <= '0;
      end else if (state_d == S_INIT) begin
         baddr_q <= '0;
         rc_q    <= '0;
         pcnt_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: wcnt_q <= block_data_en ? WCW'(1) : '0;
            S_LOAD: if (block_data_en && hdr_room_c) wcnt_q <= wcnt_q + WCW'(1);
            S_PRIME: begin
               baddr_q <= baddr_q + HAW'(1);
               pcnt_q  <= pcnt_q + PW'(1);
            end
            S_ROUND: begin
               if (!round_last_c)               rc_q    <= rc_q + RW'(1);
               if (rc_q < RW'(SCHED_SW_RND))    baddr_q <= baddr_q + HAW'(1);
            end
            default: ;
         endcase
      end
   end

   sha_seq_nonce_ctr u_nonce (
      .clk_h       (clk_h),
      .host_break  (host_break),
      .arm         (nonce_arm),
      .inc         (nonce_inc),
      .set_exh     (nonce_set_exh),
      .nonce_start (nonce_start),
      .nonce_end   (nonce_end),
      .nonce       (nonce_out),
      .last_c      (nonce_last_c),
      .exhausted   (exhausted)
   );

endmodule

// File: tb/tb_sha_round_seq.sv
// Directed bench for sha_round_seq (default instance plus a ROUNDS=80 instance on shared inputs).
module tb_sha_round_seq;

   logic        clk_h         = 1'b0;
   logic        host_break    = 1'b1;
   logic        block_data_en = 1'b0;
   logic        start_stop    = 1'b0;
   logic [31:0] nonce_start   = '0;
   logic [31:0] nonce_end     = '0;
   logic        ds_ready      = 1'b0;

   logic        hdr_wren, k_en, abc_load, abc_en, wt_reg_en, wt_sw, wr_nonce;
   logic        go_next, busy, exhausted;
   logic [4:0]  hdr_addr_a, hdr_addr_b;
   logic [5:0]  k_addr;
   logic [31:0] nonce_out;

   logic        hdr_wren_80, k_en_80, abc_load_80, abc_en_80, wt_reg_en_80, wt_sw_80, wr_nonce_80;
   logic        go_next_80, busy_80, exhausted_80;
   logic [4:0]  hdr_addr_a_80, hdr_addr_b_80;
   logic [6:0]  k_addr_80;
   logic [31:0] nonce_out_80;

   int n_checks = 0;
   int n_fail   = 0;

   // monitor state
   logic        mon_clr = 1'b1;
   int          cyc, cyc_init, cyc_go, cyc_go80;
   int          n_wrn, n_xfer, n_wren_busy, n_ken, rnd, rnd80;
   int          sw_rc, sw_rc80;
   logic        init_seen, go_seen, go_seen80, sw_seen, sw_seen80;
   logic [31:0] init_nonce;
   logic [4:0]  init_addr;
   logic [31:0] xq[$];

   sha_round_seq dut (
      .clk_h(clk_h), .host_break(host_break), .block_data_en(block_data_en),
      .start_stop(start_stop), .nonce_start(nonce_start), .nonce_end(nonce_end),
      .ds_ready(ds_ready), .hdr_wren(hdr_wren), .hdr_addr_a(hdr_addr_a),
      .hdr_addr_b(hdr_addr_b), .k_addr(k_addr), .k_en(k_en), .abc_load(abc_load),
      .abc_en(abc_en), .wt_reg_en(wt_reg_en), .wt_sw(wt_sw), .wr_nonce(wr_nonce),
      .nonce_out(nonce_out), .go_next(go_next), .busy(busy), .exhausted(exhausted)
   );

   sha_round_seq #(.ROUNDS(80)) dut80 (
      .clk_h(clk_h), .host_break(host_break), .block_data_en(block_data_en),
      .start_stop(start_stop), .nonce_start(nonce_start), .nonce_end(nonce_end),
      .ds_ready(ds_ready), .hdr_wren(hdr_wren_80), .hdr_addr_a(hdr_addr_a_80),
      .hdr_addr_b(hdr_addr_b_80), .k_addr(k_addr_80), .k_en(k_en_80), .abc_load(abc_load_80),
      .abc_en(abc_en_80), .wt_reg_en(wt_reg_en_80), .wt_sw(wt_sw_80), .wr_nonce(wr_nonce_80),
      .nonce_out(nonce_out_80), .go_next(go_next_80), .busy(busy_80), .exhausted(exhausted_80)
   );

   always #5 clk_h = ~clk_h;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   // Event monitor, sampled on the falling edge.
   always @(negedge clk_h) begin
      if (mon_clr) begin
         cyc = 0; cyc_init = 0; cyc_go = 0; cyc_go80 = 0;
         n_wrn = 0; n_xfer = 0; n_wren_busy = 0; n_ken = 0; rnd = 0; rnd80 = 0;
         sw_rc = -1; sw_rc80 = -1;
         init_seen = 1'b0; go_seen = 1'b0; go_seen80 = 1'b0; sw_seen = 1'b0; sw_seen80 = 1'b0;
         init_nonce = '0; init_addr = '0;
         xq.delete();
      end else if (!host_break) begin
         cyc++;
         if (wr_nonce) begin
            n_wrn++;
            if (!init_seen) begin
               init_seen = 1'b1; cyc_init = cyc; init_nonce = nonce_out; init_addr = hdr_addr_a;
            end
         end
         if (go_next && !go_seen)       begin go_seen = 1'b1;   cyc_go = cyc;   end
         if (go_next_80 && !go_seen80)  begin go_seen80 = 1'b1; cyc_go80 = cyc; end
         if (go_next && ds_ready)       begin n_xfer++; xq.push_back(nonce_out); end
         if (hdr_wren && busy)          n_wren_busy++;
         if (k_en)                      n_ken++;
         if (abc_en && !abc_load)       rnd++;
         if (abc_en_80 && !abc_load_80) rnd80++;
         if (wt_sw && !sw_seen)         begin sw_seen = 1'b1;   sw_rc = int'(k_addr);      end
         if (wt_sw_80 && !sw_seen80)    begin sw_seen80 = 1'b1; sw_rc80 = int'(k_addr_80); end
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_h);
      #1;
   endtask

   task automatic do_reset();
      tick();
      host_break = 1'b1; mon_clr = 1'b1;
      block_data_en = 1'b0; start_stop = 1'b0; ds_ready = 1'b0;
      nonce_start = '0; nonce_end = '0;
      tick();
      tick();
      host_break = 1'b0; mon_clr = 1'b0;
   endtask

   task automatic load(input int n, input string tag);
      int cnt, errs;
      cnt = 0; errs = 0;
      for (int i = 0; i < n; i++) begin
         block_data_en = 1'b1;
         @(negedge clk_h);
         if (hdr_wren) begin
            if (hdr_addr_a != 5'(cnt)) errs++;
            cnt++;
         end
         tick();
      end
      block_data_en = 1'b0;
      check_eq({tag, "_wren_cnt"}, 64'(cnt), 64'((n < 20) ? n : 20));
      check_eq({tag, "_wren_addr_errs"}, 64'(errs), 64'd0);
   endtask

   task automatic start_run(input logic [31:0] s, input logic [31:0] e, input logic rdy);
      nonce_start = s; nonce_end = e; ds_ready = rdy; start_stop = 1'b1;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int i;
      i = 0;
      @(negedge clk_h);
      while (busy && i < budget) begin @(negedge clk_h); i++; end
      check_eq({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   task automatic wait_run(input int budget, input string tag);
      int i;
      i = 0;
      @(negedge clk_h);
      while (!busy && i < 8) begin @(negedge clk_h); i++; end
      check_eq({tag, "_started"}, 64'(busy), 64'd1);
      wait_idle(budget, tag);
   endtask

   task automatic wait_go(input int budget, input string tag);
      int i;
      i = 0;
      @(negedge clk_h);
      while (!go_next && i < budget) begin @(negedge clk_h); i++; end
      check_eq({tag, "_go"}, 64'(go_next), 64'd1);
   endtask

   // Waits until the default instance is in ROUND with the given round counter.
   task automatic wait_rc(input int target, input int budget, input string tag);
      int i;
      i = 0;
      @(negedge clk_h);
      while (!(abc_en && !abc_load && k_addr == 6'(target)) && i < budget) begin
         @(negedge clk_h); i++;
      end
      check_eq({tag, "_rc"}, 64'(k_addr), 64'(target));
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_bits"},
               64'({hdr_wren, k_en, abc_load, abc_en, wt_reg_en, wt_sw, wr_nonce, go_next, busy, exhausted}),
               64'd0);
      check_eq({tag, "_addrs"}, 64'({hdr_addr_a, hdr_addr_b, k_addr}), 64'd0);
      check_eq({tag, "_nonce"}, 64'(nonce_out), 64'd0);
   endtask

   initial begin
      int i;
      int x0;
      logic [5:0] kfz;
      int hold_go, hold_k;

      // Reset state
      do_reset();
      @(negedge clk_h);
      check_quiet("rst");

      // Single nonce 5..5; ROUNDS=80 instance runs alongside
      do_reset();
      load(20, "t1");
      start_run(32'd5, 32'd5, 1'b1);
      wait_run(300, "t1");
      i = 0;
      while (busy_80 && i < 100) begin @(negedge clk_h); i++; end
      check_eq("t1_80_idle", 64'(busy_80), 64'd0);
      check_eq("t1_wr_nonce_cnt", 64'(n_wrn), 64'd1);
      check_eq("t1_init_nonce", 64'(init_nonce), 64'd5);
      check_eq("t1_init_addr", 64'(init_addr), 64'd19);
      check_eq("t1_go_latency", 64'(cyc_go - cyc_init), 64'(1 + 4 + 64));
      check_eq("t1_xfer_cnt", 64'(n_xfer), 64'd1);
      check_eq("t1_xfer_nonce", 64'((xq.size() > 0) ? xq[0] : 32'hDEAD_BEEF), 64'd5);
      check_eq("t1_exhausted", 64'(exhausted), 64'd1);
      check_eq("t1_round_cycles", 64'(rnd), 64'd64);
      check_eq("t1_k_en_cycles", 64'(n_ken), 64'd65);
      check_eq("t1_wt_sw_rc", 64'(sw_rc), 64'd16);
      check_eq("r80_go_latency", 64'(cyc_go80 - cyc_init), 64'(1 + 4 + 80));
      check_eq("r80_round_cycles", 64'(rnd80), 64'd80);
      check_eq("r80_wt_sw_rc", 64'(sw_rc80), 64'd16);
      check_eq("r80_exhausted", 64'(exhausted_80), 64'd1);

      // Wrap-edge range FFFFFFFE..FFFFFFFF
      do_reset();
      load(20, "t2");
      start_run(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1);
      wait_run(400, "t2");
      check_eq("t2_xfer_cnt", 64'(n_xfer), 64'd2);
      check_eq("t2_xfer0", 64'((xq.size() > 0) ? xq[0] : 32'hDEAD_BEEF), 64'hFFFF_FFFE);
      check_eq("t2_xfer1", 64'((xq.size() > 1) ? xq[1] : 32'hDEAD_BEEF), 64'hFFFF_FFFF);
      check_eq("t2_wr_nonce_cnt", 64'(n_wrn), 64'd2);
      check_eq("t2_exhausted", 64'(exhausted), 64'd1);

      // Reversed range runs the start nonce only
      do_reset();
      load(20, "t3");
      start_run(32'd9, 32'd3, 1'b1);
      wait_run(300, "t3");
      check_eq("t3_xfer_cnt", 64'(n_xfer), 64'd1);
      check_eq("t3_xfer_nonce", 64'((xq.size() > 0) ? xq[0] : 32'hDEAD_BEEF), 64'd9);
      check_eq("t3_exhausted", 64'(exhausted), 64'd1);

      // Downstream back-pressure for 10 cycles
      do_reset();
      load(20, "t4");
      start_run(32'd7, 32'd7, 1'b0);
      wait_go(150, "t4");
      kfz = 6'd63;
      hold_go = 0; hold_k = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_h);
         if (go_next) hold_go++;
         if (k_addr == kfz) hold_k++;
      end
      check_eq("t4_go_held", 64'(hold_go), 64'd10);
      check_eq("t4_k_frozen", 64'(hold_k), 64'd10);
      tick();
      ds_ready = 1'b1;
      tick();
      ds_ready = 1'b0;
      wait_idle(20, "t4");
      check_eq("t4_xfer_cnt", 64'(n_xfer), 64'd1);
      check_eq("t4_exhausted", 64'(exhausted), 64'd1);

      // host_break in the middle of ROUND (rc=30), then a clean reload
      do_reset();
      load(20, "t5");
      start_run(32'd1, 32'd3, 1'b1);
      wait_rc(29, 100, "t5");
      tick();
      host_break = 1'b1;
      tick();
      host_break = 1'b0;
      @(negedge clk_h);
      check_quiet("t5_brk");
      x0 = n_xfer;
      check_eq("t5_no_xfer", 64'(x0), 64'd0);
      tick();
      start_stop = 1'b0;
      load(20, "t5r");
      start_run(32'd9, 32'd9, 1'b1);
      wait_run(300, "t5r");
      check_eq("t5r_xfer_cnt", 64'(n_xfer - x0), 64'd1);
      check_eq("t5r_xfer_nonce", 64'((xq.size() > 0) ? xq[xq.size() - 1] : 32'hDEAD_BEEF), 64'd9);
      check_eq("t5r_exhausted", 64'(exhausted), 64'd1);

      // host_break beats a pending ds_ready handshake
      do_reset();
      load(20, "t6");
      start_run(32'd2, 32'd2, 1'b0);
      wait_go(150, "t6");
      tick();
      ds_ready = 1'b1; host_break = 1'b1;
      tick();
      ds_ready = 1'b0; host_break = 1'b0;
      @(negedge clk_h);
      check_eq("t6_xfer_cnt", 64'(n_xfer), 64'd0);
      check_quiet("t6_brk");

      // start_stop drops mid-ROUND; header strobes during the run are ignored
      do_reset();
      load(20, "t7");
      start_run(32'd10, 32'd12, 1'b1);
      wait_rc(20, 100, "t7");
      tick();
      start_stop = 1'b0;
      block_data_en = 1'b1;
      wait_idle(200, "t7");
      check_eq("t7_xfer_cnt", 64'(n_xfer), 64'd1);
      check_eq("t7_xfer_nonce", 64'((xq.size() > 0) ? xq[0] : 32'hDEAD_BEEF), 64'd10);
      check_eq("t7_exhausted", 64'(exhausted), 64'd0);
      check_eq("t7_wren_in_run", 64'(n_wren_busy), 64'd0);

      // Oversized header: 25 words offered, 20 written
      do_reset();
      load(25, "t8");
      @(negedge clk_h);
      check_eq("t8_not_busy", 64'(busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
